// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the configurable UART.
// Parity modes, FSM encodings and legal payload width bounds.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  function automatic logic par_bit(
    input logic [1:0] mode,
    input logic       x
  );
    logic p;
    unique case (mode)
      PAR_EVEN: p = x;
      PAR_ODD:  p = ~x;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts div clocks per bit while run is high.
// bit_end pulses on the last cycle of each bit period.
module uart_bit_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 run,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] last;

  // div of 0 behaves as 1 so a reused timer never stalls
  assign last = (div == '0) ? '0 : div - DIV_WIDTH'(1);
  assign bit_end = run && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (!run)         cnt_d = '0;
    else if (bit_end) cnt_d = '0;
    else              cnt_d = cnt_q + DIV_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with run-time divisor, parity and
// stop-bit selection, latched per frame; all outputs registered.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);

  state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           idx_q, idx_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           mode_q, mode_d;
  logic                 stop2_q, stop2_d;
  logic                 par_q, par_d;
  logic tx_q, tx_d, busy_q, busy_d;
  logic done_q, done_d, rdy_q, rdy_d;
  logic bit_end;

  uart_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .div    (div_q),
    .run    (state_q != ST_IDLE),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    div_d   = div_q;
    mode_d  = mode_q;
    stop2_d = stop2_q;
    par_d   = par_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && rdy_q) begin
          shift_d = in_data;
          div_d   = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
          mode_d  = cfg_parity;
          stop2_d = cfg_stop2;
          par_d   = par_bit(cfg_parity, ^in_data);
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = (mode_q != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && idx_q == 4'd0) begin
            idx_d = 4'd1;
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // outputs are registered, so decode from the next state
    tx_d = 1'b1;
    unique case (1'b1)
      (state_d == ST_START):  tx_d = 1'b0;
      (state_d == ST_DATA):   tx_d = shift_d[0];
      (state_d == ST_PARITY): tx_d = par_d;
      default:                tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    rdy_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      div_q   <= DIV_WIDTH'(1);
      mode_q  <= PAR_NONE;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = rdy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed checks of the configurable UART transmitter.
// Cycle c of a capture is the value seen #1 after accept edge T+c-1.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        in_ready, tx, busy, done;
  logic [7:0]  src5;
  logic        in_valid5;
  logic        in_ready5, tx5, busy5, done5;

  int checks = 0;
  int failures = 0;

  logic w_tx[0:511];
  logic w_done[0:511];
  logic w_busy[0:511];
  logic w_rdy[0:511];
  logic ebits[0:15];
  int   nbits;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .DIV_WIDTH(16)) u8 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .tx(tx), .busy(busy), .done(done)
  );

  uart_tx_cfg #(.DATA_BITS(5), .DIV_WIDTH(16)) u5 (
    .clk(clk), .rst(rst), .in_data(src5[4:0]), .in_valid(in_valid5),
    .in_ready(in_ready5), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .tx(tx5), .busy(busy5), .done(done5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // par < 0 means no parity bit
  task automatic build(input logic [7:0] d, input int nd,
                       input int par, input logic s2);
    nbits = 0;
    ebits[nbits] = 1'b0; nbits = nbits + 1;
    for (int i = 0; i < nd; i++) begin
      ebits[nbits] = d[i]; nbits = nbits + 1;
    end
    if (par >= 0) begin
      ebits[nbits] = par[0]; nbits = nbits + 1;
    end
    ebits[nbits] = 1'b1; nbits = nbits + 1;
    if (s2) begin
      ebits[nbits] = 1'b1; nbits = nbits + 1;
    end
  endtask

  task automatic start(input bit sel, input logic [7:0] d,
                       input logic [15:0] div, input logic [1:0] par,
                       input logic s2, output bit ok);
    int n = 0;
    if (sel) src5 = d; else in_data = d;
    cfg_div = div; cfg_parity = par; cfg_stop2 = s2;
    if (sel) in_valid5 = 1'b1; else in_valid = 1'b1;
    while (((sel ? in_ready5 : in_ready) !== 1'b1) && n < 100) begin
      tick(); n++;
    end
    ok = ((sel ? in_ready5 : in_ready) === 1'b1);
    tick();
    in_valid = 1'b0; in_valid5 = 1'b0;
  endtask

  task automatic cap(input bit sel, input int n);
    for (int c = 1; c <= n; c++) begin
      w_tx[c]   = sel ? tx5 : tx;
      w_done[c] = sel ? done5 : done;
      w_busy[c] = sel ? busy5 : busy;
      w_rdy[c]  = sel ? in_ready5 : in_ready;
      if (c < n) tick();
    end
  endtask

  // first cycle whose tx differs from the expected frame, 0 if none
  function automatic int wave_err(input int d, input int off, input int len);
    for (int c = 1; c <= len; c++)
      if (w_tx[off+c] !== ebits[(c-1)/d]) return c;
    return 0;
  endfunction

  function automatic int first_done(input int n);
    for (int c = 1; c <= n; c++)
      if (w_done[c] === 1'b1) return c;
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; cfg_div = 16'd1;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0; src5 = 8'h00; in_valid5 = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({tx, busy, done, in_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_outputs got %b expected 1000",
               {tx, busy, done, in_ready});
    end
    checks++;
    if (in_ready5 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready5 got %b expected 0", in_ready5);
    end
    in_valid = 1'b0; rst = 1'b0;
    tick();
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release got %b expected 10", {in_ready, busy});
    end
  endtask

  task automatic test_8n1();
    bit ok; int e; int nb;
    start(1'b0, 8'hA5, 16'd4, 2'b00, 1'b0, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL 8n1_accept timeout got 0 expected 1");
    end
    cap(1'b0, 42);
    build(8'hA5, 8, -1, 1'b0);
    e = wave_err(4, 0, 40);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL 8n1_wave cycle %0d got %b expected %b",
               e, w_tx[e], ebits[(e-1)/4]);
    end
    nb = 0;
    for (int c = 1; c <= 40; c++) if (w_busy[c] !== 1'b1) nb++;
    checks++;
    if (nb != 0) begin
      failures++; $display("FAIL 8n1_busy low_cycles got %0d expected 0", nb);
    end
    checks++;
    if (first_done(42) != 41) begin
      failures++;
      $display("FAIL 8n1_done cycle got %0d expected 41", first_done(42));
    end
    checks++;
    if ({w_rdy[40], w_rdy[41], w_busy[41], w_done[42]} !== 4'b0100) begin
      failures++;
      $display("FAIL 8n1_end got %b expected 0100",
               {w_rdy[40], w_rdy[41], w_busy[41], w_done[42]});
    end
  endtask

  task automatic test_parity();
    bit ok; int e;
    logic [1:0] modes[3] = '{2'b01, 2'b10, 2'b11};
    int         pexp[3]  = '{1, 0, 1};
    for (int m = 0; m < 3; m++) begin
      start(1'b0, 8'h07, 16'd2, modes[m], 1'b0, ok);
      cap(1'b0, 23);
      build(8'h07, 8, pexp[m], 1'b0);
      e = wave_err(2, 0, 22);
      checks++;
      if (!ok || e != 0) begin
        failures++;
        $display("FAIL parity_wave mode %0d cycle %0d got %b expected %b",
                 m + 1, e, w_tx[e], ebits[(e-1)/2]);
      end
      checks++;
      if ({w_tx[19], w_tx[20]} !== {2{pexp[m][0]}}) begin
        failures++;
        $display("FAIL parity_bit mode %0d got %b%b expected %0d",
                 m + 1, w_tx[19], w_tx[20], pexp[m]);
      end
      checks++;
      if (first_done(23) != 23) begin
        failures++;
        $display("FAIL parity_done mode %0d got %0d expected 23",
                 m + 1, first_done(23));
      end
    end
  endtask

  task automatic test_stop2();
    bit ok; int e; int nh;
    start(1'b0, 8'h3C, 16'd3, 2'b00, 1'b1, ok);
    cap(1'b0, 35);
    build(8'h3C, 8, -1, 1'b1);
    e = wave_err(3, 0, 33);
    checks++;
    if (!ok || e != 0) begin
      failures++;
      $display("FAIL stop2_wave cycle %0d got %b expected %b",
               e, w_tx[e], ebits[(e-1)/3]);
    end
    nh = 0;
    for (int c = 28; c <= 33; c++) if (w_tx[c] === 1'b1) nh++;
    checks++;
    if (nh != 6 || w_tx[27] !== 1'b0) begin
      failures++;
      $display("FAIL stop2_high cycles got %0d expected 6", nh);
    end
    checks++;
    if (first_done(35) != 34) begin
      failures++;
      $display("FAIL stop2_done got %0d expected 34", first_done(35));
    end
  endtask

  task automatic test_div0();
    bit ok; int e;
    start(1'b0, 8'h81, 16'd0, 2'b00, 1'b0, ok);
    cap(1'b0, 12);
    build(8'h81, 8, -1, 1'b0);
    e = wave_err(1, 0, 10);
    checks++;
    if (!ok || e != 0) begin
      failures++;
      $display("FAIL div0_wave cycle %0d got %b expected %b",
               e, w_tx[e], ebits[e-1]);
    end
    checks++;
    if (first_done(12) != 11) begin
      failures++;
      $display("FAIL div0_done got %0d expected 11", first_done(12));
    end
  endtask

  task automatic test_width5();
    bit ok; int e;
    start(1'b1, 8'h3F, 16'd2, 2'b00, 1'b0, ok);
    cap(1'b1, 17);
    build(8'h1F, 5, -1, 1'b0);
    e = wave_err(2, 0, 14);
    checks++;
    if (!ok || e != 0) begin
      failures++;
      $display("FAIL w5_wave cycle %0d got %b expected %b",
               e, w_tx[e], ebits[(e-1)/2]);
    end
    checks++;
    if (first_done(17) != 15) begin
      failures++;
      $display("FAIL w5_done got %0d expected 15", first_done(17));
    end
  endtask

  task automatic test_back_to_back();
    int n = 0; int e;
    in_data = 8'h55; cfg_div = 16'd2; cfg_parity = 2'b00;
    cfg_stop2 = 1'b0; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    tick();
    for (int c = 1; c <= 43; c++) begin
      w_tx[c] = tx; w_done[c] = done; w_rdy[c] = in_ready;
      if (c == 5)  begin cfg_div = 16'd8; in_data = 8'hAA; end
      if (c == 15) cfg_div = 16'd2;
      if (c == 22) in_valid = 1'b0;
      if (c < 43) tick();
    end
    build(8'h55, 8, -1, 1'b0);
    e = wave_err(2, 0, 20);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL b2b_first cycle %0d got %b expected %b",
               e, w_tx[e], ebits[(e-1)/2]);
    end
    checks++;
    if ({w_tx[21], w_done[21], w_rdy[21], w_tx[22]} !== 4'b1110) begin
      failures++;
      $display("FAIL b2b_gap got %b expected 1110",
               {w_tx[21], w_done[21], w_rdy[21], w_tx[22]});
    end
    build(8'hAA, 8, -1, 1'b0);
    e = wave_err(2, 21, 20);
    checks++;
    if (e != 0) begin
      failures++;
      $display("FAIL b2b_second cycle %0d got %b expected %b",
               e + 21, w_tx[e+21], ebits[(e-1)/2]);
    end
    checks++;
    if (w_done[42] !== 1'b1) begin
      failures++; $display("FAIL b2b_done2 got %b expected 1", w_done[42]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int e;
    start(1'b0, 8'hF0, 16'd4, 2'b00, 1'b0, ok);
    cap(1'b0, 14);
    checks++;
    if (w_tx[14] !== 1'b0 || w_busy[14] !== 1'b1) begin
      failures++;
      $display("FAIL rmid_before got %b%b expected 01", w_tx[14], w_busy[14]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({tx, busy, done, in_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL rmid_abort got %b expected 1000",
               {tx, busy, done, in_ready});
    end
    rst = 1'b0;
    tick();
    cap(1'b0, 10);
    checks++;
    if (w_rdy[1] !== 1'b1 || first_done(10) != 0) begin
      failures++;
      $display("FAIL rmid_after ready %b done_at %0d expected 1 0",
               w_rdy[1], first_done(10));
    end
    start(1'b0, 8'h3C, 16'd1, 2'b00, 1'b0, ok);
    cap(1'b0, 12);
    build(8'h3C, 8, -1, 1'b0);
    e = wave_err(1, 0, 10);
    checks++;
    if (!ok || e != 0 || first_done(12) != 11) begin
      failures++;
      $display("FAIL rmid_fresh cycle %0d done_at %0d expected 0 11",
               e, first_done(12));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_div0();
    test_width5();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable UART transmitter for the serial debug/console path. It is the generalised successor to the fixed 8N1 transmitter. It accepts parallel words over a valid/ready handshake and serialises them LSB-first onto `tx`. Data width is a build-time parameter; baud divisor, parity mode and stop-bit count are selectable at run time and latched per frame.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, legal range 5..9.
- `DIV_WIDTH`, default 16: width of the baud divisor input and bit counter.
- `clk`, in, 1: single system clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_data`, in, DATA_BITS: word to send; only bits [DATA_BITS-1:0] are used.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block can accept a word this cycle.
- `cfg_div`, in, DIV_WIDTH: clock cycles per bit; 0 is treated as 1.
- `cfg_parity`, in, 2: parity mode. 00 none, 01 even, 10 odd, 11 mark (parity bit always 1).
- `cfg_stop2`, in, 1: 0 selects one stop bit, 1 selects two.
- `tx`, out, 1: serial line, idle high.
- `busy`, out, 1: high while a frame is being shifted.
- `done`, out, 1: one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `tx`=1, `busy`=0, `in_ready`=1.
  - On `in_valid && in_ready` (accept): latch `in_data`, `cfg_div` (0 becomes 1), `cfg_parity` and `cfg_stop2`, then go to START.
- START: drives `tx`=0 for div cycles, then DATA.
- DATA
  - Drives `shift[0]` for div cycles per bit, then shifts right.
  - After DATA_BITS bits, goes to PARITY if the parity mode is not 00, otherwise to STOP.
- PARITY: drives the parity bit for div cycles, then STOP.
  - Even mode: XOR of the latched data bits.
  - Odd mode: the inverse of that XOR.
  - Mark mode: 1.
- STOP: drives `tx`=1 for div cycles, or 2·div cycles when `cfg_stop2` was latched high; then IDLE.
- Config inputs and `in_data` are ignored while not in IDLE. Changing them mid-frame has no effect on the current frame.
- `in_ready` is low in every state except IDLE; the block does not accept a word during STOP.
- Frame length N = 1 + DATA_BITS + (parity≠00 ? 1 : 0) + (stop2 ? 2 : 1) bits.
- Bit counter: DIV_WIDTH bits, counts 0..div-1, and the bit-end event fires at div-1. The bit index counter is 4 bits wide.
- Reset
  - Every output is registered.
  - While `rst` is high: `tx`=1, `busy`=0, `done`=0, `in_ready`=0, state IDLE, counters 0.
  - `in_ready` rises on the first cycle after `rst` deasserts.
- Reset mid-frame aborts the frame immediately. `tx` is 1 on the cycle after the `rst` edge, and no `done` pulse is produced.

## Timing
- Cycle numbering: accept on the rising edge at cycle T.
  - `tx` goes low and `busy` goes high from cycle T+1.
  - Bit k (start bit = 0) occupies cycles T+1+k·div .. T+(k+1)·div.
  - The last stop bit ends at cycle T+N·div.
- Completion: at cycle T+N·div+1, `done`=1 for one cycle, `busy`=0 and `in_ready`=1.
- Back-to-back: if `in_valid` is held high, the next accept happens at T+N·div+1. The line therefore sees exactly one extra idle-high cycle between frames, and the next start bit begins at T+N·div+2.
- Simultaneous `rst` and `in_valid`: reset wins and nothing is accepted.

## Structure
- Shared package `uart_pkg` holds:
  - the parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK);
  - the state encodings;
  - the legal DATA_BITS bounds.
- The bit-period counter is a natural sub-module, `uart_bit_timer`.
  - Inputs: `clk`, `rst`, `div`, `run`. Output: a one-cycle `bit_end` pulse.
  - It is intended for reuse by a future configurable receiver.
- The top level holds the FSM, the shift register and the parity computation.

## Test plan
- 8N1 frame: div=4, 0xA5 → `tx` shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles. `done` at T+41, `in_ready` at T+41.
- Parity: 8 bits, div=2, 0x07. Even mode → parity bit 1; odd mode → 0; mark mode → 1. Frames are 11 bits, 22 cycles.
- Stop bits and divisor edge: `cfg_stop2`=1, div=3 → stop high for 6 cycles. `cfg_div`=0 → every bit lasts 1 cycle; 8N1 `done` at T+11.
- DATA_BITS=5, 0x1F with bit 5 of the source forced high → exactly 5 data bits sent. Frame is 7 bits.
- Back-to-back: `in_valid` held high with 0x55 then 0xAA at div=2 → second start bit at T+22 (one idle cycle). `cfg_div` changed to 8 mid-frame has no effect on the current frame.
- Reset mid-DATA: `rst` pulsed for 1 cycle at bit 3 → `tx`=1, `busy`=0 next cycle, no `done`. `in_ready`=1 the cycle after `rst` falls, and a fresh frame then transmits correctly.
